vector_sum_scheduler: RTL and testbench
=======================================

# vector_sum_scheduler

Shares one serial vector-summation datapath among NUM_REQ requesters. Each requester presents a packed vector of NUM_INPUTS elements of INPUT_WIDTH bits. The block arbitrates round-robin, latches the winning vector and sums it LANES elements per cycle into a modulo-2^INPUT_WIDTH accumulator. It returns the sum tagged with the requester ID over a valid/ready response port. It sits between multiple producer engines and the downstream consumer of vector sums.

## Interface
- NUM_INPUTS, 8, elements per vector.
- INPUT_WIDTH, 8, element and sum width in bits.
- NUM_REQ, 4, number of requesters; must be ≥2.
- LANES, 2, elements summed per cycle; must divide NUM_INPUTS.
- ID_W, derived = $clog2(NUM_REQ), width of the response ID; not overridable.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  NUM_REQ*NUM_INPUTS*INPUT_WIDTH  requester r's vector at [r*NUM_INPUTS*INPUT_WIDTH +: NUM_INPUTS*INPUT_WIDTH]; element i at [i*INPUT_WIDTH +: INPUT_WIDTH] within it.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  INPUT_WIDTH  sum of the granted vector, modulo 2^INPUT_WIDTH.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- **IDLE**
  - If any req_valid is high, the arbiter selects requester g. The search runs round-robin, starting at last_grant+1 and wrapping.
  - req_ready[g] is driven high combinationally in the same cycle.
  - On that edge the block latches req_data slice g and g, clears acc and idx to 0, sets last_grant = g, and moves to ACCUM.
  - If no req_valid is high, req_ready is all zero and the block stays in IDLE.
- **ACCUM**
  - Each cycle: acc <= acc + element[idx] + … + element[idx+LANES-1], all truncated to INPUT_WIDTH; then idx <= idx + LANES.
  - The transition to DONE happens on the cycle that consumes the last lane group, when idx == NUM_INPUTS-LANES.
  - req_ready is all zero.
- **DONE**
  - rsp_valid = 1; rsp_sum = acc; rsp_id = latched g.
  - All three outputs hold stable until rsp_ready = 1. On that edge the block returns to IDLE.
  - req_ready is all zero.
- Requesters hold req_valid and req_data stable until req_ready. After acceptance the block no longer samples req_data.
- Arithmetic:
  - All additions wrap modulo 2^INPUT_WIDTH; no carry or overflow flag is produced.
  - The lane partial sum is also INPUT_WIDTH wide, which gives an identical result modulo 2^INPUT_WIDTH.
- Fairness: a requester with a continuously held req_valid is granted within NUM_REQ jobs.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_id = 0, busy = 0, last_grant = NUM_REQ-1, acc = 0, idx = 0. After reset, requester 0 has first priority.
- Latency:
  - Take the acceptance edge as cycle 0.
  - ACCUM occupies cycles 1..NUM_INPUTS/LANES.
  - rsp_valid is first high in cycle NUM_INPUTS/LANES+1; with the defaults this is cycle 5.
- Throughput: one job per NUM_INPUTS/LANES+2 cycles, assuming rsp_ready is tied high. There is one IDLE cycle between DONE and the next grant.
- Simultaneous valids: exactly one grant per IDLE cycle. Unserved requesters keep waiting.
- req_valid toggling during ACCUM or DONE has no effect.
- Response backpressure: the block stalls in DONE indefinitely. No new grant is issued and busy stays high.
- Reset mid-operation: rsp_valid and busy drop immediately, without waiting for a clock edge. The in-flight job is discarded and is not re-issued; the requester must resubmit.

## Structure
- Package vector_sum_pkg holds:
  - the state enum typedef (IDLE, ACCUM, DONE);
  - the element-width and ID-width helper localparams;
  - a function that extracts element i from a packed vector.
- Sub-module rr_arbiter (parameter NUM_REQ) contains:
  - a request vector input and an enable input;
  - a one-hot grant output and an encoded grant index output;
  - the last_grant pointer, updated only on an enabled grant.
- The FSM, vector latch, lane adder and accumulator live in the top module.

## Test plan
- Requester 0 sends elements 1..8, rsp_ready held high → rsp_sum = 36, rsp_id = 0, rsp_valid first high 5 cycles after acceptance and high for exactly 1 cycle.
- Requester 2 sends all elements 0xFF → rsp_sum = 0xF8, rsp_id = 2 (wrap-around).
- All four requesters valid from reset, each with a distinct vector → grants in order 0,1,2,3; the IDs match the vectors. Requester 0 then re-requests and is granted after requester 3.
- rsp_ready held low for 10 cycles in DONE while requester 1 is valid → rsp_sum and rsp_id stable, req_ready stays 0, busy = 1. Requester 1 is granted the cycle after return to IDLE.
- rst pulsed during cycle 2 of ACCUM → busy and rsp_valid go 0 asynchronously. Requester 0 resubmits elements 1..8 → sum 36, with no residue from the aborted job.
- LANES = 8 build, same vector 1..8 → rsp_sum = 36 with rsp_valid in cycle 2.

Source files
------------

// File: rtl/vector_sum_pkg.sv
// Shared types and helpers for the vector_sum_scheduler slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package vector_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default geometry helpers for integrators sizing their own buses.
  localparam int DEF_INPUT_WIDTH = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ID_W        = $clog2(DEF_NUM_REQ);

  // Upper bounds on the generic element extractor below.
  localparam int MAX_VEC_W  = 4096;
  localparam int MAX_ELEM_W = 64;

  // Element i (w bits wide) of a packed vector whose element 0 sits at the LSBs.
  // The caller zero-extends its vector to MAX_VEC_W and truncates the result.
  function automatic logic [MAX_ELEM_W-1:0] elem_at(input logic [MAX_VEC_W-1:0] vec,
                                                    input int                   i,
                                                    input int                   w);
    return MAX_ELEM_W'(vec >> (i * w)) &
           ((w >= MAX_ELEM_W) ? {MAX_ELEM_W{1'b1}}
                              : ((MAX_ELEM_W'(1) << w) - MAX_ELEM_W'(1)));
  endfunction

endpackage

// File: rtl/vector_sum_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, search starts after last winner.
// Latency: grant is combinational from req; pointer moves on the clock edge of an enabled grant.
// Backpressure: when en is low the grant is still computed but the pointer holds.
// Ports: clk, rst (async active-high), req[NUM_REQ], en, gnt[NUM_REQ] (one-hot/zero), gnt_idx.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt          = '0;
    gnt_idx      = '0;
    found        = 1'b0;
    cand         = '0;
    // Scan last_grant+1, +2, ... wrapping; the first requester hit wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
    last_grant_d = last_grant_q;
    if (en && found) begin
      last_grant_d = gnt_idx;
    end
  end

  // Reset to the highest index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/vector_sum_scheduler.sv
// Shares one serial vector-sum datapath among NUM_REQ requesters; returns sum tagged with ID.
// Latency: rsp_valid first high NUM_INPUTS/LANES+1 cycles after the acceptance edge.
// Backpressure: holds the result in DONE until rsp_ready; no new grant while busy.
// Ports: clk, rst (async active-high); req_valid/req_ready/req_data per requester;
//        rsp_valid/rsp_ready/rsp_sum/rsp_id response; busy high outside IDLE.
module vector_sum_scheduler
  import vector_sum_pkg::*;
#(
  parameter  int NUM_INPUTS  = 8,
  parameter  int INPUT_WIDTH = 8,
  parameter  int NUM_REQ     = 4,
  parameter  int LANES       = 2,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ*NUM_INPUTS*INPUT_WIDTH-1:0] req_data,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [INPUT_WIDTH-1:0]                    rsp_sum,
  output logic [ID_W-1:0]                           rsp_id,
  output logic                                      busy
);

  localparam int                VEC_W    = NUM_INPUTS * INPUT_WIDTH;
  localparam int                IDX_W    = $clog2(NUM_INPUTS) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INPUTS - LANES);
  localparam logic [IDX_W-1:0]  STEP     = IDX_W'(LANES);

  state_e                   state_q, state_d;
  logic [VEC_W-1:0]         vec_q, vec_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [INPUT_WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [INPUT_WIDTH-1:0]   lane_sum;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_idx;
  logic                     arb_en;

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Lane partial sum kept at INPUT_WIDTH: wrap here equals wrap in the accumulator.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum +
                 INPUT_WIDTH'(elem_at(MAX_VEC_W'(vec_q), int'(idx_q) + l, INPUT_WIDTH));
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    id_d    = id_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          vec_d   = req_data[int'(gnt_idx) * VEC_W +: VEC_W];
          id_d    = gnt_idx;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + lane_sum;
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      id_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them immediately.
  assign req_ready = arb_en ? gnt : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_sum_scheduler.sv
// Randomized plus directed bench for vector_sum_scheduler against a behavioural model.
// Latency: model expects rsp_valid exactly NUM_INPUTS/LANES+1 cycles after a grant.
// Backpressure: rsp_ready is held low or randomized to exercise DONE stalls.
module tb_vector_sum_scheduler;

  localparam int NI  = 8;
  localparam int W   = 8;
  localparam int NR  = 4;
  localparam int L   = 2;
  localparam int LAT = NI / L + 1;
  localparam int VW  = NI * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*VW-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic [1:0]       rsp_id;
  logic             busy;

  logic [NR-1:0]    v8_valid;
  logic [NR-1:0]    v8_ready;
  logic [NR*VW-1:0] v8_data;
  logic             v8_rsp_valid;
  logic             v8_rsp_ready;
  logic [W-1:0]     v8_sum;
  logic [1:0]       v8_id;
  logic             v8_busy;

  vector_sum_scheduler #(.NUM_INPUTS(NI), .INPUT_WIDTH(W), .NUM_REQ(NR), .LANES(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );

  vector_sum_scheduler #(.NUM_INPUTS(NI), .INPUT_WIDTH(W), .NUM_REQ(NR), .LANES(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(v8_valid), .req_ready(v8_ready), .req_data(v8_data),
    .rsp_valid(v8_rsp_valid), .rsp_ready(v8_rsp_ready), .rsp_sum(v8_sum), .rsp_id(v8_id),
    .busy(v8_busy)
  );

  int         n_vec = 0;
  int         n_miss = 0;
  int         last_g = NR - 1;
  bit         in_flight = 1'b0;
  int         cyc = 0;
  int         clear_g = -1;
  logic [7:0] exp_sum = '0;
  int         exp_id = 0;
  int         grant_log[$];
  logic [7:0] last_rsp_sum = '0;
  int         last_rsp_id = 0;
  int         n_rsp = 0;

  localparam logic [VW-1:0] VEC_1_8 = 64'h0807060504030201;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sum of all elements, reduced modulo 256 at the end.
  function automatic logic [7:0] model_sum(input logic [VW-1:0] v);
    int s = 0;
    for (int i = 0; i < NI; i++) s += int'(v[i*W +: W]);
    return 8'(s % 256);
  endfunction

  // First valid requester after the previous winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic post(input int r, input logic [VW-1:0] v);
    req_data[r*VW +: VW] = v;
    req_valid[r]         = 1'b1;
  endtask

  // Accepted requester drops valid and scribbles its data: the DUT must not resample it.
  task automatic tick();
    @(negedge clk);
    if (clear_g >= 0) begin
      req_valid[clear_g]          = 1'b0;
      req_data[clear_g*VW +: VW]  = {$urandom, $urandom};
      clear_g                     = -1;
    end
  endtask

  task automatic check_cycle();
    logic [NR-1:0] exp_rdy;
    int            g;
    #1;
    if (in_flight) begin
      cyc++;
      chk_eq("busy_job", busy, 1);
      chk_eq("req_ready_job", req_ready, 0);
      chk_eq("rsp_valid_timing", rsp_valid, cyc >= LAT);
      if (rsp_valid) begin
        chk_eq("rsp_sum", rsp_sum, exp_sum);
        chk_eq("rsp_id", rsp_id, exp_id);
        if (rsp_ready) begin
          last_rsp_sum = rsp_sum;
          last_rsp_id  = int'(rsp_id);
          n_rsp++;
          in_flight    = 1'b0;
        end
      end
    end else begin
      chk_eq("busy_idle", busy, 0);
      chk_eq("rsp_valid_idle", rsp_valid, 0);
      g       = rr_pick(req_valid, last_g);
      exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
      chk_eq("req_ready_grant", req_ready, exp_rdy);
      if (g >= 0) begin
        in_flight = 1'b1;
        cyc       = 0;
        last_g    = g;
        exp_sum   = model_sum(req_data[g*VW +: VW]);
        exp_id    = g;
        clear_g   = g;
        grant_log.push_back(g);
      end
    end
  endtask

  task automatic drive_rand();
    for (int r = 0; r < NR; r++) begin
      if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
        post(r, ($urandom_range(0, 5) == 0) ? {VW{1'b1}} : {$urandom, $urandom});
      end
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step_n(input int n, input bit rnd);
    repeat (n) begin
      tick();
      if (rnd) drive_rand();
      check_cycle();
    end
  endtask

  task automatic run_until_rsp(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      tick();
      check_cycle();
      k++;
    end
    chk_eq("rsp_timeout", n_rsp >= target, 1);
  endtask

  task automatic assert_reset();
    rst       = 1'b1;
    req_valid = '0;
    last_g    = NR - 1;
    in_flight = 1'b0;
    clear_g   = -1;
    cyc       = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int k;
    int base;
    int held;
    bit reposted;

    req_valid    = '0;
    req_data     = '0;
    rsp_ready    = 1'b0;
    v8_valid     = '0;
    v8_data      = '0;
    v8_rsp_ready = 1'b0;

    // Reset values, observed while rst is still asserted.
    #1 rst = 1'b1;
    #3;
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_sum", rsp_sum, 0);
    chk_eq("rst_rsp_id", rsp_id, 0);
    chk_eq("rst_busy", busy, 0);

    // Requester 0, elements 1..8.
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    post(0, VEC_1_8);
    check_cycle();
    run_until_rsp(1, 20);
    chk_eq("t1_sum", last_rsp_sum, 36);
    chk_eq("t1_id", last_rsp_id, 0);
    step_n(1, 1'b0);

    // Requester 2, all 0xFF: wraps to 0xF8.
    tick();
    post(2, {VW{1'b1}});
    check_cycle();
    run_until_rsp(2, 20);
    chk_eq("t2_sum", last_rsp_sum, 8'hF8);
    chk_eq("t2_id", last_rsp_id, 2);

    // All four valid from reset; requester 0 re-requests after its grant.
    tick();
    assert_reset();
    tick();
    tick();
    for (int r = 0; r < NR; r++) post(r, {8{8'(8'h11 * (r + 1))}} ^ {$urandom, $urandom});
    rst = 1'b0;
    grant_log.delete();
    check_cycle();
    reposted = 1'b0;
    k = 0;
    while (grant_log.size() < 5 && k < 60) begin
      tick();
      if (!reposted && !req_valid[0]) begin
        post(0, {$urandom, $urandom});
        reposted = 1'b1;
      end
      check_cycle();
      k++;
    end
    chk_eq("t3_grants", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk_eq("t3_order", grant_log[i], exp_order[i]);
    step_n(8, 1'b0);

    // Response stall: 10 cycles with rsp_ready low while requester 1 waits.
    tick();
    rsp_ready = 1'b0;
    post(2, {$urandom, $urandom});
    check_cycle();
    tick();
    post(1, {$urandom, $urandom});
    check_cycle();
    held = 0;
    k = 0;
    while (held < 10 && k < 40) begin
      tick();
      check_cycle();
      if (rsp_valid) held++;
      k++;
    end
    chk_eq("t4_held", held, 10);
    tick();
    rsp_ready = 1'b1;
    check_cycle();
    tick();
    check_cycle();
    chk_eq("t4_next_grant", grant_log[$], 1);
    step_n(8, 1'b0);

    // Reset during cycle 2 of ACCUM, then resubmit.
    tick();
    post(0, VEC_1_8);
    check_cycle();
    step_n(2, 1'b0);
    #2;
    assert_reset();
    #1;
    chk_eq("t5_busy_async", busy, 0);
    chk_eq("t5_rsp_valid_async", rsp_valid, 0);
    chk_eq("t5_req_ready_async", req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    post(0, VEC_1_8);
    check_cycle();
    base = n_rsp;
    run_until_rsp(base + 1, 20);
    chk_eq("t5_sum", last_rsp_sum, 36);
    chk_eq("t5_id", last_rsp_id, 0);

    // Random traffic and backpressure, then drain.
    step_n(400, 1'b1);
    rsp_ready = 1'b1;
    k = 0;
    while ((req_valid != '0 || in_flight) && k < 200) begin
      tick();
      check_cycle();
      k++;
    end
    chk_eq("drain", {in_flight, req_valid}, 0);

    // LANES = 8 build: whole vector in one ACCUM cycle, rsp_valid in cycle 2.
    @(negedge clk);
    v8_data[VW-1:0] = VEC_1_8;
    v8_valid        = 4'b0001;
    v8_rsp_ready    = 1'b1;
    #1;
    chk_eq("l8_ready", v8_ready, 4'b0001);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      v8_valid = '0;
      #1;
      chk_eq("l8_rsp_valid", v8_rsp_valid, c == 2);
      if (c == 2) begin
        chk_eq("l8_sum", v8_sum, 36);
        chk_eq("l8_id", v8_id, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
